alu_uart_sequencer: RTL and testbench

Front-end sequencer that drives the registered ALU from a byte stream and returns its result. It sits between the UART receiver/transmitter pair and the ALU. It collects three received bytes in fixed order (operand 1, operand 2, opcode), presents them to the ALU, and waits a fixed ALU latency. It then hands the 8-bit result to the UART transmitter with a start/done handshake.

---
 rtl/alu_uart_sequencer.sv | 109 ++++++++++
 tb/tb_alu_uart_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_sequencer.sv
// Byte-stream front end for the registered ALU: collects operand 1, operand 2 and opcode
// from the UART receiver, waits out the ALU latency and hands the result to the transmitter.
module alu_uart_sequencer #(
  parameter int NB_DATA     = 8,
  parameter int NB_OPCODE   = 6,
  parameter int ALU_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_tx_done,
  output logic [NB_DATA-1:0]   o_ope1,
  output logic [NB_DATA-1:0]   o_ope2,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_drop
);

  typedef enum logic [2:0] {
    GET_OPE1,
    GET_OPE2,
    GET_OPCODE,
    WAIT_ALU,
    SEND,
    WAIT_TX
  } state_t;

  localparam logic [2:0] LAT = 3'(ALU_LATENCY);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       busy_state;

  // Upper opcode-byte bits are intentionally discarded.
  logic unused_rx_hi;
  assign unused_rx_hi = ^i_rx_data[NB_DATA-1:NB_OPCODE];

  assign busy_state = (state == WAIT_ALU) || (state == SEND) || (state == WAIT_TX);

  // NOTE: all state and outputs are updated with non-blocking assignments so every
  // register samples pre-edge values; the one-cycle pulses default to 0 each edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= GET_OPE1;
      lat_cnt    <= '0;
      o_ope1     <= '0;
      o_ope2     <= '0;
      o_opcode   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_drop     <= i_rx_done && busy_state;

      case (state)
        GET_OPE1: begin
          if (i_rx_done) begin
            o_ope1 <= i_rx_data;
            state  <= GET_OPE2;
          end
        end
        GET_OPE2: begin
          if (i_rx_done) begin
            o_ope2 <= i_rx_data;
            state  <= GET_OPCODE;
          end
        end
        GET_OPCODE: begin
          if (i_rx_done) begin
            o_opcode <= i_rx_data[NB_OPCODE-1:0];
            lat_cnt  <= '0;
            o_busy   <= 1'b1;
            state    <= WAIT_ALU;
          end
        end
        WAIT_ALU: begin
          // Counter value k on the edge N+1+k after opcode capture.
          if (lat_cnt == LAT) begin
            o_tx_data  <= i_alu_result;
            o_tx_start <= 1'b1;
            state      <= SEND;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= GET_OPE1;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= GET_OPE1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench for alu_uart_sequencer: a small registered ALU model feeds i_alu_result,
// expected results are queued when the opcode is sent and popped on each o_tx_start.
module tb_alu_uart_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_alu_result;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_ope1, o_ope2, o_tx_data;
  logic [5:0] o_opcode;
  logic       o_tx_start, o_busy, o_drop;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   drop_seen = 0;
  logic prev_start = 1'b0;

  alu_uart_sequencer #(.NB_DATA(8), .NB_OPCODE(6), .ALU_LATENCY(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_alu_result (i_alu_result),
    .i_tx_done    (i_tx_done),
    .o_ope1       (o_ope1),
    .o_ope2       (o_ope2),
    .o_opcode     (o_opcode),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy),
    .o_drop       (o_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      default: return 8'h00;
    endcase
  endfunction

  // Registered ALU, one edge of latency.
  always @(posedge clk) i_alu_result <= alu_fn(o_ope1, o_ope2, o_opcode);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard monitor: result data, sample edge and single-cycle start width.
  always @(negedge clk) begin
    if (rst) begin
      if (o_drop) drop_seen++;
      if (o_tx_start) begin
        check("tx_start_width", {31'b0, prev_start}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_tx", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("tx_data", {24'b0, o_tx_data}, {24'b0, e.data});
          check("tx_cycle", cyc, e.cyc);
        end
      end
      prev_start = o_tx_start;
    end
  end

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic rx(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic send_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    exp_t e;
    rx(a);
    check("ope1", {24'b0, o_ope1}, {24'b0, a});
    rx(b);
    check("ope2", {24'b0, o_ope2}, {24'b0, b});
    rx(op);
    check("opcode", {26'b0, o_opcode}, {26'b0, op[5:0]});
    check("busy_after_opcode", {31'b0, o_busy}, 32'd1);
    e.data = alu_fn(a, b, op[5:0]);
    e.cyc  = cyc + 2;
    sb.push_back(e);
  endtask

  // Waits for the transmit request, then lands in WAIT_TX at a negedge.
  task automatic wait_tx;
    int n = 0;
    while (!o_tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", {31'b0, o_tx_start}, 32'd1);
    @(negedge clk);
    check("busy_wait_tx", {31'b0, o_busy}, 32'd1);
  endtask

  task automatic ack_tx;
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    check("busy_after_ack", {31'b0, o_busy}, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    // Reset held while bytes arrive: nothing captured, all outputs zero.
    for (int i = 0; i < 3; i++) rx(8'h99 + 8'(i));
    check("rst_ope1", {24'b0, o_ope1}, 32'd0);
    check("rst_ope2", {24'b0, o_ope2}, 32'd0);
    check("rst_opcode", {26'b0, o_opcode}, 32'd0);
    check("rst_tx_data", {24'b0, o_tx_data}, 32'd0);
    check("rst_tx_start", {31'b0, o_tx_start}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_drop", {31'b0, o_drop}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // First byte after reset is operand 1.
    send_txn(8'h11, 8'h22, 8'h20);
    wait_tx;
    ack_tx;

    // ADD with 8-bit wrap.
    send_txn(8'hF1, 8'hFF, 8'h20);
    wait_tx;
    ack_tx;

    // Opcode masking; operand 2 holds until re-received.
    rx(8'h0A);
    check("ope2_held", {24'b0, o_ope2}, 32'hFF);
    check("opcode_held", {26'b0, o_opcode}, 32'h20);
    rx(8'h03);
    rx(8'hE2);
    check("opcode_masked", {26'b0, o_opcode}, 32'h22);
    begin
      exp_t e;
      e.data = 8'h07;
      e.cyc  = cyc + 2;
      sb.push_back(e);
    end
    wait_tx;
    ack_tx;

    // Drop in WAIT_TX, then drop on the same edge as i_tx_done.
    send_txn(8'h10, 8'h20, 8'h25);
    wait_tx;
    rx(8'h55);
    check("drop_wait_tx", {31'b0, o_drop}, 32'd1);
    check("drop_ope1_kept", {24'b0, o_ope1}, 32'h10);
    @(negedge clk);
    check("drop_one_cycle", {31'b0, o_drop}, 32'd0);
    check("still_wait_tx", {31'b0, o_busy}, 32'd1);
    i_rx_data = 8'h55;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    check("drop_with_ack", {31'b0, o_drop}, 32'd1);
    check("busy_with_ack", {31'b0, o_busy}, 32'd0);
    check("ope1_after_ack", {24'b0, o_ope1}, 32'h10);
    send_txn(8'h77, 8'h01, 8'h20);
    wait_tx;
    ack_tx;

    // Reset mid-transaction discards partial operands.
    rx(8'h01);
    rx(8'h02);
    rst = 1'b0;
    #2;
    check("midrst_ope1", {24'b0, o_ope1}, 32'd0);
    check("midrst_ope2", {24'b0, o_ope2}, 32'd0);
    check("midrst_opcode", {26'b0, o_opcode}, 32'd0);
    check("midrst_tx_data", {24'b0, o_tx_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_txn(8'h03, 8'h04, 8'h24);
    wait_tx;
    ack_tx;

    // Back-to-back bytes, second transaction right after the acknowledge.
    send_txn(8'h05, 8'h06, 8'h20);
    wait_tx;
    ack_tx;
    send_txn(8'h40, 8'h07, 8'h20);
    wait_tx;
    ack_tx;

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    check("drop_total", drop_seen, 32'd2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
